// File: rtl/uart_cmd_led_ctrl.sv
// uart_cmd_led_ctrl: validates 32-bit UART command frames and drives LEDs in static/blink/run/off modes.
// Optional ack path (ack_data/ack_send_en/ack_tx_done) is built when UART_LED_ACK_EN is defined.
module uart_cmd_led_ctrl #(
  parameter int          CLK_FREQ = 50_000_000,
  parameter int          TICK_MS  = 10,
  parameter int          LED_NUM  = 4,
  parameter logic [7:0]  HEADER   = 8'h55
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic [31:0]        data,
  input  logic               Rx_Done,
  input  logic               timeout_flag,
  output logic [LED_NUM-1:0] led,
  output logic               cmd_valid,
  output logic               cmd_err,
  output logic [2:0]         err_code
`ifdef UART_LED_ACK_EN
  ,
  output logic [7:0]         ack_data,
  output logic               ack_send_en,
  input  logic               ack_tx_done
`endif
);
  localparam int TICK_CYC = CLK_FREQ / 1000 * TICK_MS;
  localparam int TW = TICK_CYC > 1 ? $clog2(TICK_CYC) : 1;
  typedef enum logic [2:0] {IDLE, CHECK, EXEC, ACK, ACK_WAIT} state_t;
  // cmd[1:0] of 01..04 maps directly onto these encodings (04 -> OFF)
  typedef enum logic [1:0] {M_OFF, M_STATIC, M_BLINK, M_RUN} mode_t;
  state_t        state, nxt;
  mode_t         mode;
  logic [31:0]   frame_r;
  logic          to_r, err_f, phase, tick, step, apply;
  logic [2:0]    err_c;
  logic [7:0]    hdr, cmd, arg, chk, per, pcnt;
  logic [TW-1:0] tick_cnt;
  logic [LED_NUM-1:0] pat;
  assign hdr   = frame_r[31:24];
  assign cmd   = frame_r[23:16];
  assign arg   = frame_r[15:8];
  assign chk   = frame_r[7:0];
  assign err_c = to_r ? 3'd1 : hdr != HEADER ? 3'd2 : chk != (hdr ^ cmd ^ arg) ? 3'd3 :
                 (cmd == 8'd0 || cmd > 8'd4) ? 3'd4 : 3'd0;
  assign apply = state == CHECK && err_c == 3'd0;
  assign tick  = tick_cnt == TW'(TICK_CYC - 1);
  assign step  = tick && pcnt + 8'd1 >= per;
  // state register
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) state <= IDLE;
    else state <= nxt;
  // next-state logic; frames arriving outside IDLE are simply not picked up
  always_comb begin
    nxt = IDLE;
    case (state)
      IDLE:     nxt = Rx_Done ? CHECK : IDLE;
      CHECK:    nxt = EXEC;
`ifdef UART_LED_ACK_EN
      EXEC:     nxt = ACK;
      ACK:      nxt = ACK_WAIT;
      ACK_WAIT: nxt = ack_tx_done ? IDLE : ACK_WAIT;
`else
      EXEC:     nxt = IDLE;
`endif
      default:  nxt = IDLE;
    endcase
  end
  // outputs decoded from state and the check result latched in CHECK
  always_comb begin
    cmd_valid   = state == EXEC && !err_f;
    cmd_err     = state == EXEC && err_f;
`ifdef UART_LED_ACK_EN
    ack_send_en = state == ACK;
    ack_data    = state != ACK ? 8'h00 : err_f ? (8'hE0 | {5'd0, err_code}) : 8'hA0;
`endif
  end
  // frame capture and check result; err_code only moves on a rejection
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) begin
      frame_r  <= '0;
      to_r     <= 1'b0;
      err_f    <= 1'b0;
      err_code <= 3'd0;
    end else begin
      if (state == IDLE && Rx_Done) begin
        frame_r <= data;
        to_r    <= timeout_flag;
      end
      if (state == CHECK) begin
        err_f <= err_c != 3'd0;
        if (err_c != 3'd0) err_code <= err_c;
      end
    end
  // free-running mode time base
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) tick_cnt <= '0;
    else tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
  // command application at the CHECK->EXEC edge so led changes together with the pulse
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) begin
      mode  <= M_OFF;
      per   <= 8'd0;
      pcnt  <= 8'd0;
      phase <= 1'b0;
      pat   <= '0;
      led   <= '0;
    end else if (apply) begin
      mode  <= mode_t'(cmd[1:0]);
      per   <= arg == 8'd0 ? 8'd1 : arg;
      pcnt  <= 8'd0;
      phase <= 1'b0;
      pat   <= led;
      led   <= cmd == 8'd1 ? arg[LED_NUM-1:0] : cmd == 8'd3 ? LED_NUM'(1) : '0;
    end else if (tick) begin
      pcnt <= step ? 8'd0 : pcnt + 8'd1;
      if (step && mode == M_BLINK) begin
        phase <= !phase;
        led   <= phase ? '0 : pat;
      end
      if (step && mode == M_RUN) led <= (led << 1) | (led >> (LED_NUM - 1));
    end
endmodule

// File: tb/tb_uart_cmd_led_ctrl.sv
// tb_uart_cmd_led_ctrl: directed frames with a scoreboard checking every cmd_valid/cmd_err pulse.
module tb_uart_cmd_led_ctrl;
  logic        Clk = 1'b0, Rst_n = 1'b0, Rx_Done = 1'b0, timeout_flag = 1'b0;
  logic [31:0] data = '0;
  logic [3:0]  led;
  logic        cmd_valid, cmd_err;
  logic [2:0]  err_code;
`ifdef UART_LED_ACK_EN
  logic [7:0]  ack_data;
  logic        ack_send_en;
  logic        ack_tx_done = 1'b0;
`endif
  int n_cmp = 0, n_bad = 0, cyc = 0, dt = 0;
  typedef struct {logic err; logic [2:0] code; logic [3:0] led; int cyc;} exp_t;
  exp_t q[$];

  uart_cmd_led_ctrl #(.CLK_FREQ(1_000_000), .TICK_MS(1), .LED_NUM(4), .HEADER(8'h55)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .data(data), .Rx_Done(Rx_Done), .timeout_flag(timeout_flag),
    .led(led), .cmd_valid(cmd_valid), .cmd_err(cmd_err), .err_code(err_code)
`ifdef UART_LED_ACK_EN
    , .ack_data(ack_data), .ack_send_en(ack_send_en), .ack_tx_done(ack_tx_done)
`endif
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  function void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // monitor: every pulse must match the oldest outstanding expectation
  always @(negedge Clk)
    if (Rst_n && (cmd_valid || cmd_err)) begin
      exp_t e;
      if (q.size() == 0) chk("unexpected_pulse", {30'd0, cmd_valid, cmd_err}, 32'd0);
      else begin
        e = q.pop_front();
        chk("pulse_is_err", cmd_err, e.err);
        chk("pulse_is_valid", cmd_valid, !e.err);
        chk("pulse_cycle", cyc, e.cyc);
        chk("err_code", err_code, e.code);
        chk("led_at_pulse", led, e.led);
      end
    end

  // send a frame and queue its expected response; extra>0 keeps Rx_Done high with another frame
  task automatic issue(input logic [31:0] d, input logic to, input logic e, input logic [2:0] c,
                       input logic [3:0] l, input int extra);
    exp_t x;
    @(negedge Clk);
    data = d; timeout_flag = to; Rx_Done = 1'b1;
    x.err = e; x.code = c; x.led = l; x.cyc = cyc + 2;
    q.push_back(x);
    for (int i = 0; i < extra; i++) begin
      @(negedge Clk);
      data = 32'h5504_0051; timeout_flag = 1'b0;
    end
    @(negedge Clk);
    Rx_Done = 1'b0; timeout_flag = 1'b0;
  endtask

  task automatic raw(input logic [31:0] d);
    @(negedge Clk);
    data = d; Rx_Done = 1'b1;
    @(negedge Clk);
    Rx_Done = 1'b0;
  endtask

`ifdef UART_LED_ACK_EN
  task automatic wait_ack(input logic [7:0] exp);
    int k = 0;
    while (!ack_send_en && k < 20) begin
      @(negedge Clk);
      k++;
    end
    chk("ack_send_en", ack_send_en, 1);
    chk("ack_data", ack_data, exp);
  endtask

  task automatic ack_done();
    @(negedge Clk); ack_tx_done = 1'b1;
    @(negedge Clk); ack_tx_done = 1'b0;
  endtask
`endif

  task automatic cmd(input logic [31:0] d, input logic to, input logic e, input logic [2:0] c,
                     input logic [3:0] l, input int extra);
    issue(d, to, e, c, l, extra);
`ifdef UART_LED_ACK_EN
    wait_ack(e ? (8'hE0 | {5'd0, c}) : 8'hA0);
    ack_done();
`endif
    repeat (3) @(negedge Clk);
  endtask

  task automatic wait_change(input logic [3:0] prev, output int d);
    d = 0;
    while (led === prev && d < 5000) begin
      @(negedge Clk);
      d++;
    end
  endtask

  initial begin
    repeat (3) @(negedge Clk);
    chk("rst_led", led, 0);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_cmd_err", cmd_err, 0);
    chk("rst_err_code", err_code, 0);
`ifdef UART_LED_ACK_EN
    chk("rst_ack_send_en", ack_send_en, 0);
    chk("rst_ack_data", ack_data, 0);
`endif
    Rst_n = 1'b1;
    repeat (2) @(negedge Clk);
    cmd(32'h5501_0A5E, 0, 0, 3'd0, 4'b1010, 0);
    cmd(32'h5501_0A5F, 0, 1, 3'd3, 4'b1010, 0);
    cmd(32'h5601_0A5D, 0, 1, 3'd2, 4'b1010, 0);
    cmd(32'h5507_0052, 0, 1, 3'd4, 4'b1010, 0);
    cmd(32'h5501_0A5E, 1, 1, 3'd1, 4'b1010, 0);
    cmd(32'h5501_0F5B, 0, 0, 3'd1, 4'b1111, 0);
    // blink with P=2: 0 first, then 2000-cycle halves
    cmd(32'h5502_0255, 0, 0, 3'd1, 4'b0000, 0);
    wait_change(4'b0000, dt);
    chk("blink_first_on", led, 4'b1111);
    chk("blink_first_within_2000", dt <= 2000, 1);
    wait_change(4'b1111, dt);
    chk("blink_off", led, 4'b0000);
    chk("blink_on_len", dt, 2000);
    wait_change(4'b0000, dt);
    chk("blink_on_again", led, 4'b1111);
    chk("blink_off_len", dt, 2000);
    // frames overlapping CHECK/EXEC are dropped
    cmd(32'h5501_0357, 0, 0, 3'd1, 4'b0011, 2);
    repeat (5) @(negedge Clk);
    chk("drop_led_kept", led, 4'b0011);
    cmd(32'h5504_0051, 0, 0, 3'd1, 4'b0000, 0);
    // running light with arg=0 -> P=1
    cmd(32'h5503_0056, 0, 0, 3'd1, 4'b0001, 0);
    wait_change(4'b0001, dt);
    chk("run_b1", led, 4'b0010);
    chk("run_first_within_1000", dt <= 1000, 1);
    wait_change(4'b0010, dt);
    chk("run_b2", led, 4'b0100);
    chk("run_step_b2", dt, 1000);
    wait_change(4'b0100, dt);
    chk("run_b3", led, 4'b1000);
    chk("run_step_b3", dt, 1000);
    wait_change(4'b1000, dt);
    chk("run_wrap", led, 4'b0001);
    chk("run_step_wrap", dt, 1000);
    // asynchronous reset mid-run
    repeat (300) @(negedge Clk);
    #2 Rst_n = 1'b0;
    #1;
    chk("async_rst_led", led, 0);
    chk("async_rst_err_code", err_code, 0);
    chk("async_rst_cmd_valid", cmd_valid, 0);
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    repeat (3000) @(negedge Clk);
    chk("off_after_reset", led, 0);
`ifdef UART_LED_ACK_EN
    issue(32'h5501_0357, 0, 0, 3'd0, 4'b0011, 0);
    wait_ack(8'hA0);
    raw(32'h5501_0F5B);
    repeat (5) @(negedge Clk);
    chk("ack_wait_drop_led", led, 4'b0011);
    ack_done();
    cmd(32'h5501_0F5B, 0, 0, 3'd0, 4'b1111, 0);
`endif
    repeat (10) @(negedge Clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
